// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler: channel state, mode encoding, defaults.
package tick_sched_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } ch_state_e;

    localparam logic ModePeriodic = 1'b0;
    localparam logic ModeOneshot  = 1'b1;

    localparam int unsigned DefPrescale = 100000;
    localparam int unsigned DefCw       = 16;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: base_tick is a registered one-cycle strobe every PRESCALE clocks.
module tick_prescaler
    import tick_sched_pkg::*;
#(
    parameter int unsigned PRESCALE = DefPrescale
) (
    input  logic clk,
    input  logic rst,
    output logic base_tick
);

    localparam int unsigned CntW = $clog2(PRESCALE);

    logic [CntW-1:0] r_cnt;
    logic            r_base_tick;
    logic            w_wrap;

    assign w_wrap = (r_cnt == CntW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_base_tick <= 1'b0;
        end else begin
            r_cnt       <= w_wrap ? '0 : r_cnt + CntW'(1);
            r_base_tick <= w_wrap;
        end
    end

    assign base_tick = r_base_tick;

endmodule

// File: rtl/tick_scheduler.sv
// NCH independent down-counting timer channels sharing one base-tick prescaler.
// Define TICK_SCHED_STATUS_EN to add the stat_ch/stat_count live-count readback.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int unsigned PRESCALE = DefPrescale,
    parameter int unsigned NCH      = 4,
    parameter int unsigned CW       = DefCw,
    localparam int unsigned ChW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [ChW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_period,
    input  logic           cfg_oneshot,
    input  logic           cfg_en,
    output logic           base_tick,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] busy
`ifdef TICK_SCHED_STATUS_EN
    ,
    input  logic [ChW-1:0] stat_ch,
    output logic [CW-1:0]  stat_count
`endif
);

    logic           w_base_tick;
    logic           w_accept;
    logic           r_started;
    ch_state_e      r_state    [NCH];
    ch_state_e      w_state_d  [NCH];
    logic [CW-1:0]  r_count    [NCH];
    logic [CW-1:0]  w_count_d  [NCH];
    logic [CW-1:0]  r_period   [NCH];
    logic [CW-1:0]  w_period_d [NCH];
    logic           r_mode     [NCH];
    logic           w_mode_d   [NCH];
    logic [NCH-1:0] r_tick;
    logic [NCH-1:0] w_tick_d;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .base_tick (w_base_tick)
    );

    // Writes are blocked on base_tick cycles, so a channel never sees a write and a tick together.
    assign cfg_ready = r_started & ~w_base_tick;
    assign w_accept  = cfg_valid & cfg_ready;
    assign base_tick = w_base_tick;

    always_comb begin
        w_tick_d = '0;
        for (int i = 0; i < NCH; i++) begin
            w_state_d[i]  = r_state[i];
            w_count_d[i]  = r_count[i];
            w_period_d[i] = r_period[i];
            w_mode_d[i]   = r_mode[i];
            if (w_accept && int'(cfg_ch) == i) begin
                if (cfg_en && cfg_period != '0) begin
                    w_state_d[i]  = StRun;
                    w_count_d[i]  = cfg_period;
                    w_period_d[i] = cfg_period;
                    w_mode_d[i]   = cfg_oneshot ? ModeOneshot : ModePeriodic;
                end else begin
                    w_state_d[i] = StIdle;
                    w_count_d[i] = '0;
                end
            end else if (r_state[i] == StRun && w_base_tick) begin
                if (r_count[i] == CW'(1)) begin
                    w_tick_d[i] = 1'b1;
                    if (r_mode[i] == ModePeriodic) begin
                        w_count_d[i] = r_period[i];
                    end else begin
                        w_state_d[i] = StIdle;
                        w_count_d[i] = '0;
                    end
                end else begin
                    w_count_d[i] = r_count[i] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_started <= 1'b0;
            r_tick    <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_state[i]  <= StIdle;
                r_count[i]  <= '0;
                r_period[i] <= '0;
                r_mode[i]   <= ModePeriodic;
            end
        end else begin
            r_started <= 1'b1;
            r_tick    <= w_tick_d;
            for (int i = 0; i < NCH; i++) begin
                r_state[i]  <= w_state_d[i];
                r_count[i]  <= w_count_d[i];
                r_period[i] <= w_period_d[i];
                r_mode[i]   <= w_mode_d[i];
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NCH; i++) begin
            busy[i] = (r_state[i] == StRun);
        end
    end

    assign tick = r_tick;

`ifdef TICK_SCHED_STATUS_EN
    always_comb begin
        stat_count = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(stat_ch) == i && r_state[i] == StRun) begin
                stat_count = r_count[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler (PRESCALE=4, NCH=4, CW=8); tick expectations via scoreboard.
module tb_tick_scheduler;

    localparam int PRESCALE = 4;
    localparam int NCH      = 4;
    localparam int CW       = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_ch = '0;
    logic [CW-1:0]  cfg_period = '0;
    logic           cfg_oneshot = 1'b0;
    logic           cfg_en = 1'b0;
    logic           base_tick;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] busy;
`ifdef TICK_SCHED_STATUS_EN
    logic [1:0]     stat_ch = '0;
    logic [CW-1:0]  stat_count;
`endif

    typedef struct {
        int             t;
        logic [NCH-1:0] mask;
    } sb_t;

    typedef struct {
        int ch;
        int period;
        bit oneshot;
        bit en;
        int run;
        int n_ticks;
        bit busy_exp;
    } row_t;

    sb_t  sb_q[$];
    row_t rows[8];
    int   cyc;
    int   n_checks = 0;
    int   n_errors = 0;

    tick_scheduler #(
        .PRESCALE (PRESCALE),
        .NCH      (NCH),
        .CW       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
        .cfg_en      (cfg_en),
        .base_tick   (base_tick),
        .tick        (tick),
        .busy        (busy)
`ifdef TICK_SCHED_STATUS_EN
        ,
        .stat_ch     (stat_ch),
        .stat_count  (stat_count)
`endif
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ticks(input int ch, input int wc, input int period, input int n);
        int             t1;
        logic [NCH-1:0] m;
        m     = '0;
        m[ch] = 1'b1;
        t1    = PRESCALE * (wc / PRESCALE) + PRESCALE * period + 1;
        for (int k = 0; k < n; k++) begin
            sb_q.push_back('{t: t1 + PRESCALE * period * k, mask: m});
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_write(input int ch, input int period, input bit oneshot, input bit en,
                            output int wc);
        int guard;
        guard       = 0;
        cfg_ch      = 2'(ch);
        cfg_period  = 8'(period);
        cfg_oneshot = oneshot;
        cfg_en      = en;
        cfg_valid   = 1'b1;
        while (!cfg_ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        check("cfg_ready_wait", cfg_ready, 1);
        wc = cyc;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Per-cycle monitor: prescaler strobe, ready, and tick against the scoreboard.
    always @(negedge clk) begin : mon
        logic [NCH-1:0] exp_m;
        if (!rst) begin
            exp_m = '0;
            for (int k = sb_q.size() - 1; k >= 0; k--) begin
                if (sb_q[k].t == cyc) begin
                    exp_m = exp_m | sb_q[k].mask;
                    sb_q.delete(k);
                end
            end
            if (exp_m != '0 || tick != '0) check("tick", int'(tick), int'(exp_m));
            check("base_tick", int'(base_tick), int'(cyc > 0 && cyc % PRESCALE == 0));
            check("cfg_ready", int'(cfg_ready), int'(cyc > 0 && cyc % PRESCALE != 0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wc;
        int wc2;
        int ws;
        int c;
        int stat_exp[6];

        //           ch per os    en    run ticks busy
        rows[0] = '{0, 3,   1'b0, 1'b1, 37, 3, 1'b1};
        rows[1] = '{1, 2,   1'b1, 1'b1, 30, 1, 1'b0};
        rows[2] = '{2, 1,   1'b0, 1'b1,  9, 2, 1'b1};
        rows[3] = '{3, 5,   1'b1, 1'b1, 13, 0, 1'b1};
        rows[4] = '{0, 0,   1'b0, 1'b1, 10, 0, 1'b0};
        rows[5] = '{1, 4,   1'b0, 1'b0, 10, 0, 1'b0};
        rows[6] = '{3, 255, 1'b0, 1'b1,  6, 0, 1'b1};
        rows[7] = '{1, 1,   1'b1, 1'b1,  5, 1, 1'b0};
        stat_exp = '{5, 4, 3, 2, 1, 5};

        repeat (3) @(negedge clk);
        check("rst_base_tick", int'(base_tick), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cfg_ready", int'(cfg_ready), 0);
        rst = 1'b0;
        wait_until(17);
        check("idle_busy", int'(busy), 0);

        for (int r = 0; r < 8; r++) begin
            while (cyc % PRESCALE != 1) @(negedge clk);
            do_write(rows[r].ch, rows[r].period, rows[r].oneshot, rows[r].en, wc);
            push_ticks(rows[r].ch, wc, rows[r].period, rows[r].n_ticks);
            wait_until(wc + rows[r].run);
            check($sformatf("row%0d_busy", r), int'(busy[rows[r].ch]), int'(rows[r].busy_exp));
            do_write(rows[r].ch, 0, 1'b0, 1'b0, ws);
            wait_until(ws + 2);
            check($sformatf("row%0d_stop_busy", r), int'(busy[rows[r].ch]), 0);
        end

        // Rewriting a running channel restarts its countdown.
        while (cyc % PRESCALE != 1) @(negedge clk);
        do_write(0, 3, 1'b0, 1'b1, wc);
        wait_until(wc + 8);
        do_write(0, 3, 1'b0, 1'b1, wc2);
        push_ticks(0, wc2, 3, 1);
        wait_until(wc2 + 13);
        do_write(0, 0, 1'b0, 1'b0, ws);
        wait_until(ws + 2);
        check("restart_stop_busy", int'(busy[0]), 0);

        // Write presented on a base_tick cycle is held off by one cycle.
        while (cyc % PRESCALE != 0) @(negedge clk);
        c           = cyc;
        cfg_ch      = 2'd1;
        cfg_period  = 8'd2;
        cfg_oneshot = 1'b1;
        cfg_en      = 1'b1;
        cfg_valid   = 1'b1;
        check("hs_ready_low", int'(cfg_ready), 0);
        @(negedge clk);
        check("hs_not_yet_busy", int'(busy[1]), 0);
        check("hs_ready_high", int'(cfg_ready), 1);
        wc = cyc;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("hs_busy", int'(busy[1]), 1);
        check("hs_accept_cycle", wc, c + 1);
        push_ticks(1, wc, 2, 1);
        wait_until(wc + 12);
        check("hs_oneshot_done", int'(busy[1]), 0);

`ifdef TICK_SCHED_STATUS_EN
        stat_ch = 2'd0;
        while (cyc % PRESCALE != 1) @(negedge clk);
        do_write(0, 5, 1'b0, 1'b1, wc);
        push_ticks(0, wc, 5, 1);
        for (int k = 0; k < 6; k++) begin
            wait_until(wc + 2 + PRESCALE * k);
            check($sformatf("stat_count%0d", k), int'(stat_count), stat_exp[k]);
        end
        wait_until(wc + 23);
        do_write(0, 0, 1'b0, 1'b0, ws);
        wait_until(ws + 2);
        check("stat_idle", int'(stat_count), 0);
`endif

        // Two channels expiring on the same base tick, then reset mid-run.
        while (cyc % PRESCALE != 1) @(negedge clk);
        do_write(2, 1, 1'b0, 1'b1, wc);
        do_write(3, 1, 1'b0, 1'b1, wc2);
        push_ticks(2, wc, 1, 1);
        push_ticks(3, wc2, 1, 1);
        wait_until(wc + 6);
        check("sim_busy", int'(busy), 12);
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("midrst_tick", int'(tick), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_base_tick", int'(base_tick), 0);
        check("midrst_cfg_ready", int'(cfg_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);

        check("sb_leftover", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter PRESCALE, default 100000, meaning clk cycles per base tick (1 kHz at 100 MHz); legal values are 2 and above.
REQ-002 SHALL have parameter NCH, default 4, meaning number of timer channels (1..8).
REQ-003 SHALL have parameter CW, default 16, meaning channel period/count width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port cfg_valid, input, 1 bit: configuration write request.
REQ-007 SHALL have port cfg_ready, output, 1 bit: configuration write accepted when high with cfg_valid.
REQ-008 SHALL have port cfg_ch, input, $clog2(NCH) bits: target channel.
REQ-009 SHALL have port cfg_period, input, CW bits: period in base ticks.
REQ-010 SHALL have port cfg_oneshot, input, 1 bit: 1 = one-shot, 0 = periodic.
REQ-011 SHALL have port cfg_en, input, 1 bit: 1 = arm channel, 0 = stop channel.
REQ-012 SHALL have port base_tick, output, 1 bit: one-cycle prescaler strobe.
REQ-013 SHALL have port tick, output, NCH bits: one-cycle expiry pulse per channel.
REQ-014 SHALL have port busy, output, NCH bits: channel in RUN state.

Function
REQ-015 Prescaler SHALL count 0..PRESCALE-1 and wrap; base_tick SHALL be registered high for exactly one cycle each time the count equals PRESCALE-1, giving period PRESCALE.
REQ-016 Each channel SHALL be a two-state FSM: IDLE, RUN; busy[i] = (state == RUN).
REQ-017 Handshake: a write is accepted on a cycle with cfg_valid && cfg_ready; cfg_ready SHALL be low only on the cycle base_tick is high, and high otherwise.
REQ-018 Accepted write with cfg_en=1 and cfg_period != 0 SHALL load count = cfg_period, store the period and mode, and enter RUN next cycle; writing a running channel SHALL restart it.
REQ-019 Accepted write with cfg_en=0 or cfg_period=0 SHALL force IDLE next cycle, with no tick.
REQ-020 In RUN, on base_tick: if count == 1, tick[i] SHALL pulse on the next cycle and the channel SHALL either reload the period (periodic) or go IDLE (one-shot); otherwise count decrements.
REQ-021 Resulting latency: period P SHALL produce the first tick P base ticks after the load, then every P*PRESCALE cycles (periodic).
REQ-022 Multiple channels expiring on the same base_tick SHALL all pulse tick in the same cycle; there is no priority.
REQ-023 cfg_ch >= NCH SHALL be accepted and ignored.
REQ-024 Counters SHALL never wrap below 1; count arithmetic is unsigned CW-bit.

Reset
REQ-025 rst SHALL asynchronously clear the prescaler count, all channel counts, periods, and modes; force all FSMs to IDLE; and drive base_tick=0, tick=0, busy=0, cfg_ready=0.
REQ-026 cfg_ready SHALL rise on the first clk edge after rst deasserts.
REQ-027 rst asserted mid-count SHALL discard all pending ticks; no tick is emitted after release until the channel is reconfigured.

Configuration
REQ-028 When macro TICK_SCHED_STATUS_EN is defined, the block SHALL add input stat_ch ($clog2(NCH) bits) and output stat_count (CW bits) carrying the combinational live count of the selected channel (0 when IDLE).
REQ-029 When TICK_SCHED_STATUS_EN is not defined, those ports SHALL be absent and function is otherwise identical.

Structure
REQ-030 Package tick_sched_pkg SHALL hold the channel state enum (IDLE, RUN), the mode encoding constants, and the default PRESCALE/CW constants.
REQ-031 The prescaler SHALL be a sub-module tick_prescaler (clk, rst, base_tick, parameter PRESCALE), instantiated once and shared by all channels.

Verification (PRESCALE=4, NCH=4, CW=8)
REQ-032 Reset release -> base_tick pulses every 4 cycles, first on the 4th edge; tick=0, busy=0.
REQ-033 Write ch0 period=3 periodic -> tick[0] pulses on every 12th cycle; busy[0] stays 1.
REQ-034 Write ch1 period=2 one-shot -> exactly one tick[1] pulse, then busy[1]=0.
REQ-035 cfg_valid held on a base_tick cycle -> cfg_ready=0 on that cycle and the write is accepted on the next cycle.
REQ-036 ch2 and ch3 both period=1 -> tick[2] and tick[3] pulse in the same cycle; rst mid-run -> no further ticks.
REQ-037 TICK_SCHED_STATUS_EN defined, ch0 period=5 -> stat_count reads 5,4,3,2,1 across base ticks, then 5 again.
